// File: rtl/rv_mc_control_if.sv
// rv_mc_control_if: decode inputs and control outputs of the multicycle RISC-V controller.
interface rv_mc_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic funct7_i, zero_i, lt_i, ltu_i, mem_ready_i;
  logic pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, adr_src_o, illegal_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
  logic [ALU_CTRL_W-1:0] alu_control_o;
  logic [2:0] imm_src_o;
  modport slave (
    input op_i, funct3_i, funct7_i, zero_i, lt_i, ltu_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, adr_src_o, illegal_o,
    output alu_src_a_o, alu_src_b_o, result_src_o, alu_control_o, imm_src_o
  );
  modport master (
    output op_i, funct3_i, funct7_i, zero_i, lt_i, ltu_i, mem_ready_i,
    input pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, adr_src_o, illegal_o,
    input alu_src_a_o, alu_src_b_o, result_src_o, alu_control_o, imm_src_o
  );
endinterface

// File: rtl/rv_mc_control.sv
// rv_mc_control: multicycle RISC-V control FSM (Moore state outputs, gated strobes).
// Define RV_MC_FULL_BRANCH_EN to accept all six branch conditions; otherwise only beq/bne.
module rv_mc_control #(parameter int ALU_CTRL_W = 4) (
  input logic clk_i,
  input logic rst_n_i,
  rv_mc_control_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, ILLEGAL
  } state_t;
  state_t r_state, w_dec;
  logic w_br_legal, w_taken, w_is_load;
  logic [3:0] w_alu_fn;
  assign w_is_load = bus.op_i == 7'b0000011;
`ifdef RV_MC_FULL_BRANCH_EN
  assign w_br_legal = bus.funct3_i[2:1] != 2'b01;
  always_comb
    case (bus.funct3_i)
      3'b000: w_taken = bus.zero_i;
      3'b001: w_taken = !bus.zero_i;
      3'b100: w_taken = bus.lt_i;
      3'b101: w_taken = !bus.lt_i;
      3'b110: w_taken = bus.ltu_i;
      3'b111: w_taken = !bus.ltu_i;
      default: w_taken = 1'b0;
    endcase
`else
  logic w_unused;
  assign w_unused = bus.lt_i ^ bus.ltu_i;
  assign w_br_legal = bus.funct3_i[2:1] == 2'b00;
  assign w_taken = bus.funct3_i[0] ? !bus.zero_i : bus.zero_i;
`endif
  assign w_dec = (w_is_load || bus.op_i == 7'b0100011) ? MEMADR :
                 bus.op_i == 7'b0110011 ? EXEC_R :
                 bus.op_i == 7'b0010011 ? EXEC_I :
                 (bus.op_i == 7'b1100011 && w_br_legal) ? BRANCH :
                 bus.op_i == 7'b1101111 ? JAL :
                 bus.op_i == 7'b0110111 ? LUI : ILLEGAL;
  // funct7 selects sub only for register ops; sra/srl honour it in both forms
  always_comb
    case (bus.funct3_i)
      3'b000: w_alu_fn = (r_state == EXEC_R && bus.funct7_i) ? 4'd1 : 4'd0;
      3'b001: w_alu_fn = 4'd6;
      3'b010: w_alu_fn = 4'd5;
      3'b011: w_alu_fn = 4'd9;
      3'b100: w_alu_fn = 4'd4;
      3'b101: w_alu_fn = bus.funct7_i ? 4'd8 : 4'd7;
      3'b110: w_alu_fn = 4'd3;
      default: w_alu_fn = 4'd2;
    endcase
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= FETCH;
    else
      case (r_state)
        FETCH: r_state <= bus.mem_ready_i ? DECODE : FETCH;
        DECODE: r_state <= w_dec;
        MEMADR: r_state <= w_is_load ? MEMREAD : MEMWRITE;
        MEMREAD: r_state <= bus.mem_ready_i ? MEMWB : MEMREAD;
        MEMWRITE: r_state <= bus.mem_ready_i ? FETCH : MEMWRITE;
        EXEC_R, EXEC_I, JAL, LUI: r_state <= ALUWB;
        MEMWB, ALUWB, BRANCH: r_state <= FETCH;
        default: r_state <= r_state;
      endcase
  // strobes are qualified by rst_n_i so they drop the instant reset asserts
  assign bus.ir_write_o = rst_n_i && r_state == FETCH && bus.mem_ready_i;
  assign bus.pc_write_o = rst_n_i && ((r_state == FETCH && bus.mem_ready_i) || r_state == JAL ||
                                      (r_state == BRANCH && w_taken));
  assign bus.reg_write_o = rst_n_i && (r_state == MEMWB || r_state == ALUWB);
  assign bus.mem_read_o = rst_n_i && (r_state == FETCH || r_state == MEMREAD);
  assign bus.mem_write_o = rst_n_i && r_state == MEMWRITE;
  assign bus.adr_src_o = r_state == MEMREAD || r_state == MEMWRITE;
  assign bus.illegal_o = r_state == ILLEGAL;
  assign bus.alu_src_a_o = (r_state == DECODE || r_state == JAL) ? 2'd1 :
                           (r_state == MEMADR || r_state == EXEC_R || r_state == EXEC_I ||
                            r_state == BRANCH) ? 2'd2 :
                           r_state == LUI ? 2'd3 : 2'd0;
  assign bus.alu_src_b_o = (r_state == FETCH || r_state == JAL) ? 2'd2 :
                           (r_state == DECODE || r_state == MEMADR || r_state == EXEC_I ||
                            r_state == LUI) ? 2'd1 : 2'd0;
  assign bus.result_src_o = r_state == FETCH ? 2'd2 : r_state == MEMWB ? 2'd1 : 2'd0;
  assign bus.imm_src_o = r_state == DECODE ? 3'd2 :
                         r_state == MEMADR ? (w_is_load ? 3'd0 : 3'd1) :
                         r_state == JAL ? 3'd3 :
                         r_state == LUI ? 3'd4 : 3'd0;
  assign bus.alu_control_o = ALU_CTRL_W'((r_state == EXEC_R || r_state == EXEC_I) ? w_alu_fn :
                                         r_state == BRANCH ? 4'd1 : 4'd0);
endmodule

// File: doc/rv_mc_control.md
RV_MC_CONTROL -- requirements
Module: rv_mc_control

Interface
REQ-001 Parameter ALU_CTRL_W, default 4, alu_control_o width; SHALL be >= 4.
REQ-002 clk_i  in  1  clock; all state changes on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 op_i  in  7  instruction opcode from instruction register.
REQ-005 funct3_i  in  3, funct7_i  in  1 (instr bit 30)  decode fields.
REQ-006 zero_i, lt_i, ltu_i  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-007 mem_ready_i  in  1  memory access completes this cycle.
REQ-008 pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o  out  1 each  strobes.
REQ-009 adr_src_o  out  1  memory address: 0 PC, 1 ALU-out register.
REQ-010 alu_src_a_o  out  2  0 PC, 1 oldPC, 2 rs1, 3 zero; alu_src_b_o  out  2  0 rs2, 1 imm, 2 constant 4.
REQ-011 result_src_o  out  2  0 ALU-out register, 1 memory data, 2 live ALU result.
REQ-012 alu_control_o  out  ALU_CTRL_W  0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sll,7 srl,8 sra,9 sltu; upper bits zero.
REQ-013 imm_src_o  out  3  0 I,1 S,2 B,3 J,4 U; illegal_o  out  1  sticky illegal-instruction flag.

Function
REQ-014 Multicycle FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, ILLEGAL.
REQ-015 Unlisted outputs in a state SHALL be 0; state-only outputs Moore, strobes gated by mem_ready_i/flags combinationally.
REQ-016 FETCH: mem_read_o=1, adr_src=0, a=PC, b=4, add, result_src=2; ir_write_o=pc_write_o=mem_ready_i; stay until mem_ready_i=1, then DECODE.
REQ-017 DECODE: a=oldPC, b=imm, imm_src=B, add; next by op_i: 0000011/0100011 MEMADR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, other ILLEGAL.
REQ-018 MEMADR: a=rs1, b=imm, add, imm_src=I (load) or S (store); next MEMREAD or MEMWRITE.
REQ-019 MEMREAD: mem_read_o=1, adr_src=1; wait mem_ready_i, then MEMWB. MEMWB: result_src=1, reg_write_o=1, next FETCH.
REQ-020 MEMWRITE: mem_write_o=1, adr_src=1; held until mem_ready_i=1, then FETCH.
REQ-021 EXEC_R: a=rs1, b=rs2; funct3 000 add/sub (funct7), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (funct7), 110 or, 111 and; next ALUWB.
REQ-022 EXEC_I: a=rs1, b=imm, imm_src=I; as EXEC_R except funct3 000 always add, funct7 honoured only for 101; next ALUWB.
REQ-023 ALUWB: result_src=0, reg_write_o=1, next FETCH.
REQ-024 BRANCH: a=rs1, b=rs2, sub, result_src=0, pc_write_o=taken; next FETCH.
REQ-025 taken: 000 zero_i, 001 ~zero_i, 100 lt_i, 101 ~lt_i, 110 ltu_i, 111 ~ltu_i.
REQ-026 JAL: a=oldPC, b=4, add, result_src=0, pc_write_o=1, imm_src=J; next ALUWB (rd=PC+4).
REQ-027 LUI: a=zero, b=imm, imm_src=U, add; next ALUWB.
REQ-028 ILLEGAL: illegal_o=1, all strobes 0; state held until reset.
REQ-029 Branch funct3 010/011 SHALL decode to ILLEGAL in DECODE.

Reset
REQ-030 rst_n_i low: state=FETCH immediately, illegal cleared, all strobes forced 0 while low, including mid-access.
REQ-031 First rising edge after deassertion SHALL evaluate FETCH normally.

Configuration
REQ-032 Macro RV_MC_FULL_BRANCH_EN defined: all six branches per REQ-025.
REQ-033 Macro undefined: only funct3 000/001 are branches; 1xx SHALL go to ILLEGAL.

Verification
REQ-034 Reset, mem_ready_i=0 three cycles -> FETCH held, mem_read_o=1, ir_write_o=0; ready=1 -> ir_write_o=pc_write_o=1, next DECODE.
REQ-035 op 0000011, ready delayed 2 cycles in MEMREAD -> DECODE,MEMADR,MEMREAD x3,MEMWB with reg_write_o=1, result_src=1.
REQ-036 op 0110011 funct3 101 funct7 1 -> alu_control_o=8; op 0010011 funct3 000 funct7 1 -> alu_control_o=0.
REQ-037 op 1100011 funct3 001 zero_i=0 -> pc_write_o=1 in BRANCH; zero_i=1 -> 0; funct3 100 lt_i=1 -> 1 with macro, illegal_o=1 without.
REQ-038 op 0000000 -> ILLEGAL, illegal_o=1, no strobes 10 cycles; rst_n_i low mid-MEMWRITE -> mem_write_o=0 at once, FETCH after release.
